// File: rtl/breadboard_pkg.sv
// Shared definitions for the breadboard decoder: widths, the 16-entry
// breadboard truth table and the decoder FSM state encoding.
package breadboard_pkg;

    localparam int PAT_W  = 10;
    localparam int CODE_W = 4;

    // Packed with entry 15 in the most significant slot so BB_TABLE[i] is entry i.
    localparam logic [15:0][PAT_W-1:0] BB_TABLE = {
        10'h266, 10'h0E3, 10'h35B, 10'h376,
        10'h0CF, 10'h205, 10'h38D, 10'h0E9,
        10'h3B6, 10'h133, 10'h335, 10'h1EE,
        10'h1BE, 10'h318, 10'h049, 10'h194
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEARCH,
        ST_DONE
    } state_t;

endpackage

// File: rtl/breadboard_eval.sv
// Combinational breadboard model: maps a 4-bit input code to its 10-bit
// output pattern.
module breadboard_eval
    import breadboard_pkg::*;
(
    input  logic [CODE_W-1:0] idx,
    output logic [PAT_W-1:0]  pattern
);

    assign pattern = BB_TABLE[idx];

endmodule

// File: rtl/breadboard_decoder.sv
// Inverse of the breadboard: serially sweeps the table one entry per cycle
// to recover the input code for an accepted output pattern.
module breadboard_decoder
    import breadboard_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PAT_W-1:0]  in_pattern,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_code,
    output logic              out_hit,
    output logic              busy,
    output logic [CNT_W-1:0]  miss_cnt
);

    state_t             state;
    state_t             state_next;
    logic [CODE_W-1:0]  idx;
    logic [PAT_W-1:0]   pat_reg;
    logic [PAT_W-1:0]   tbl_pat;
    logic               accept;
    logic               match;
    logic               last;

    breadboard_eval u_eval (
        .idx     (idx),
        .pattern (tbl_pat)
    );

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state == ST_SEARCH);

    assign accept = in_valid && in_ready;
    assign match  = (tbl_pat == pat_reg);
    assign last   = &idx;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (in_valid)       state_next = ST_SEARCH;
            ST_SEARCH: if (match || last)  state_next = ST_DONE;
            ST_DONE:   if (out_ready)      state_next = ST_IDLE;
            default:                       state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Pattern latch is pure data; it is only consulted after a fresh accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            pat_reg <= in_pattern;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            out_code <= '0;
            out_hit  <= 1'b0;
            miss_cnt <= '0;
        end else begin
            if (accept) begin
                idx <= '0;
            end else if (busy && !match && !last) begin
                idx <= idx + CODE_W'(1);
            end

            if (busy) begin
                if (match) begin
                    out_code <= idx;
                    out_hit  <= 1'b1;
                end else if (last) begin
                    out_code <= '0;
                    out_hit  <= 1'b0;
                    if (miss_cnt != '1) begin
                        miss_cnt <= miss_cnt + CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_breadboard_decoder.sv
// Directed and randomized bench for breadboard_decoder; two instances with
// different miss-counter widths run in lockstep on the same stimulus.
module tb_breadboard_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [9:0] in_pattern = '0;
    logic       out_ready = 1'b0;

    logic       in_ready, out_valid, out_hit, busy;
    logic [3:0] out_code;
    logic [7:0] miss_cnt;
    logic       in_ready2, out_valid2, out_hit2, busy2;
    logic [3:0] out_code2;
    logic [1:0] miss_cnt2;

    int vectors = 0;
    int miscompares = 0;
    int misses = 0;

    logic [9:0] tbl [16] = '{10'h194, 10'h049, 10'h318, 10'h1BE,
                             10'h1EE, 10'h335, 10'h133, 10'h3B6,
                             10'h0E9, 10'h38D, 10'h205, 10'h0CF,
                             10'h376, 10'h35B, 10'h0E3, 10'h266};

    always #5 clk = ~clk;

    breadboard_decoder #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_pattern(in_pattern),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_code(out_code), .out_hit(out_hit),
        .busy(busy), .miss_cnt(miss_cnt)
    );

    breadboard_decoder #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready2), .in_pattern(in_pattern),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_code(out_code2), .out_hit(out_hit2),
        .busy(busy2), .miss_cnt(miss_cnt2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic lookup(input logic [9:0] pat, output bit hit, output int code);
        hit  = 1'b0;
        code = 0;
        for (int i = 0; i < 16; i++) begin
            if (tbl[i] == pat) begin
                hit  = 1'b1;
                code = i;
            end
        end
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_miss8"}, 32'(miss_cnt), (misses > 255) ? 255 : misses);
        check({tag, "_miss2"}, 32'(miss_cnt2), (misses > 3) ? 3 : misses);
    endtask

    // One transaction; called at a negedge with the block idle.
    task automatic decode(input logic [9:0] pat, input int hold, input bit early_ready);
        bit   exp_hit;
        int   exp_code;
        int   lat;
        lookup(pat, exp_hit, exp_code);
        check("in_ready_idle", 32'(in_ready), 1);
        in_valid   = 1'b1;
        in_pattern = pat;
        @(posedge clk);
        @(negedge clk);
        in_valid   = 1'b0;
        in_pattern = 10'($urandom);
        out_ready  = early_ready && (hold == 0);
        check("busy_search", 32'(busy), 1);
        check("in_ready_search", 32'(in_ready), 0);
        lat = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 40);
        if (!exp_hit) misses++;
        check("latency", lat, exp_hit ? exp_code + 1 : 16);
        check("out_code", 32'(out_code), exp_code);
        check("out_hit", 32'(out_hit), 32'(exp_hit));
        check("busy_done", 32'(busy), 0);
        check_counts("done");
        for (int c = 0; c < hold; c++) begin
            in_valid   = 1'b1;
            in_pattern = 10'($urandom);
            @(posedge clk);
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 1);
            check("hold_code", 32'(out_code), exp_code);
            check("hold_in_ready", 32'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("post_valid", 32'(out_valid), 0);
        check("post_in_ready", 32'(in_ready), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 1);
        check({tag, "_out_valid"}, 32'(out_valid), 0);
        check({tag, "_out_code"}, 32'(out_code), 0);
        check({tag, "_out_hit"}, 32'(out_hit), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check_counts(tag);
    endtask

    initial begin
        logic [9:0] pat;
        bit         h;
        int         c;

        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        decode(10'h194, 0, 1'b0);
        decode(10'h266, 0, 1'b0);
        for (int i = 0; i < 16; i++) decode(tbl[i], 0, 1'b1);

        decode(10'h000, 0, 1'b0);
        check("miss_first", 32'(miss_cnt), 1);
        decode(10'h3FF, 0, 1'b1);
        check("miss_second", 32'(miss_cnt), 2);

        decode(10'h0CF, 5, 1'b0);

        // Reset during the fifth cycle of a miss sweep.
        in_valid   = 1'b1;
        in_pattern = 10'h000;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b0;
        misses = 0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        decode(10'h38D, 0, 1'b0);

        for (int m = 0; m < 5; m++) begin
            do begin
                pat = 10'($urandom);
                lookup(pat, h, c);
            end while (h);
            decode(pat, m % 2, 1'b0);
            if (m == 3) check("sat4", 32'(miss_cnt2), 3);
        end
        check("sat5_narrow", 32'(miss_cnt2), 3);
        check("sat5_wide", 32'(miss_cnt), 5);

        for (int r = 0; r < 24; r++) begin
            if ($urandom_range(0, 1) == 1) pat = tbl[$urandom_range(0, 15)];
            else                           pat = 10'($urandom);
            decode(pat, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
